// File: rtl/datapath.sv
// datapath: fully pipelined 8-point radix-2 DIT FFT for real 8-bit samples.
// Three register stages (butterflies, 4-point DFTs, final combine). One frame
// is accepted per clock. Outputs are the non-redundant parts of X0..X4,
// scaled by 1/8.
module datapath (
    input  logic              clk_1,
    input  logic              rst_n,
    input  logic signed [7:0] in1,
    input  logic signed [7:0] in2,
    input  logic signed [7:0] in3,
    input  logic signed [7:0] in4,
    input  logic signed [7:0] in5,
    input  logic signed [7:0] in6,
    input  logic signed [7:0] in7,
    input  logic signed [7:0] in8,
    output logic signed [7:0] out1,
    output logic signed [7:0] out2,
    output logic signed [7:0] out3,
    output logic signed [7:0] out4,
    output logic signed [7:0] out5,
    output logic signed [7:0] out6,
    output logic signed [7:0] out7,
    output logic signed [7:0] out8
);

    // Q7 approximation of cos(pi/4), widened so the product never overflows.
    localparam logic signed [21:0] TW_C = 22'sd91;

    // Multiply by c and drop the Q7 fraction bits (floor).
    function automatic logic signed [13:0] tw_scale(input logic signed [13:0] v);
        logic signed [21:0] prod;
        logic signed [21:0] shifted;
        prod    = 22'(v) * TW_C;
        shifted = prod >>> 7;
        return shifted[13:0];
    endfunction

    // Final 1/8 scaling (floor) and truncation to the 8-bit output width.
    function automatic logic signed [7:0] out_scale(input logic signed [13:0] v);
        logic signed [13:0] shifted;
        shifted = v >>> 3;
        return shifted[7:0];
    endfunction

    // Sign-extend a stage-2 value to the stage-3 working width.
    function automatic logic signed [13:0] ext10(input logic signed [9:0] v);
        return 14'(v);
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: butterflies on (x0,x4), (x2,x6), (x1,x5), (x3,x7).
    // Pair index 0/1 feeds the even half, 2/3 the odd half.
    // ------------------------------------------------------------------
    logic signed [7:0] x      [8];
    logic signed [7:0] pair_a [4];
    logic signed [7:0] pair_b [4];

    assign x[0] = in1;
    assign x[1] = in2;
    assign x[2] = in3;
    assign x[3] = in4;
    assign x[4] = in5;
    assign x[5] = in6;
    assign x[6] = in7;
    assign x[7] = in8;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pair
            // gi = 0,1,2,3 selects first operand x0, x2, x1, x3.
            localparam int IA = (gi % 2) * 2 + gi / 2;
            localparam int IB = IA + 4;
            assign pair_a[gi] = x[IA];
            assign pair_b[gi] = x[IB];
        end
    endgenerate

    logic signed [8:0] s1_sum_d [4];
    logic signed [8:0] s1_dif_d [4];
    logic signed [8:0] s1_sum_q [4];
    logic signed [8:0] s1_dif_q [4];

    // Stage-1 sums and differences, 9 bits so no sample pair can overflow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s1_sum_d[i] = 9'(pair_a[i]) + 9'(pair_b[i]);
            s1_dif_d[i] = 9'(pair_a[i]) - 9'(pair_b[i]);
        end
    end

    // Stage-1 register.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                s1_sum_q[i] <= '0;
                s1_dif_q[i] <= '0;
            end
        end else begin
            s1_sum_q <= s1_sum_d;
            s1_dif_q <= s1_dif_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: two 4-point DFTs. Index 0 holds the even half (E), index 1
    // the odd half (O). Bins 0 and 2 are purely real.
    // ------------------------------------------------------------------
    logic signed [9:0] r0_d    [2];
    logic signed [9:0] r2_d    [2];
    logic signed [9:0] c1_re_d [2];
    logic signed [9:0] c1_im_d [2];
    logic signed [9:0] c3_re_d [2];
    logic signed [9:0] c3_im_d [2];
    logic signed [9:0] r0_q    [2];
    logic signed [9:0] r2_q    [2];
    logic signed [9:0] c1_re_q [2];
    logic signed [9:0] c1_im_q [2];
    logic signed [9:0] c3_re_q [2];
    logic signed [9:0] c3_im_q [2];

    // 4-point DFT: bin1 = d0 - j*d1, bin3 = d0 + j*d1.
    always_comb begin
        for (int h = 0; h < 2; h++) begin
            r0_d[h]    = 10'(s1_sum_q[2*h]) + 10'(s1_sum_q[2*h+1]);
            r2_d[h]    = 10'(s1_sum_q[2*h]) - 10'(s1_sum_q[2*h+1]);
            c1_re_d[h] = 10'(s1_dif_q[2*h]);
            c1_im_d[h] = -(10'(s1_dif_q[2*h+1]));
            c3_re_d[h] = 10'(s1_dif_q[2*h]);
            c3_im_d[h] = 10'(s1_dif_q[2*h+1]);
        end
    end

    // Stage-2 register.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < 2; h++) begin
                r0_q[h]    <= '0;
                r2_q[h]    <= '0;
                c1_re_q[h] <= '0;
                c1_im_q[h] <= '0;
                c3_re_q[h] <= '0;
                c3_im_q[h] <= '0;
            end
        end else begin
            r0_q    <= r0_d;
            r2_q    <= r2_d;
            c1_re_q <= c1_re_d;
            c1_im_q <= c1_im_d;
            c3_re_q <= c3_re_d;
            c3_im_q <= c3_im_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: combine halves with twiddles, scale by 1/8.
    // ------------------------------------------------------------------
    logic signed [13:0] w1_re;
    logic signed [13:0] w1_im;
    logic signed [13:0] w3_re;
    logic signed [13:0] w3_im;
    logic signed [13:0] x0_v;
    logic signed [13:0] x4_v;
    logic signed [13:0] x1_re;
    logic signed [13:0] x1_im;
    logic signed [13:0] x2_re;
    logic signed [13:0] x2_im;
    logic signed [13:0] x3_re;
    logic signed [13:0] x3_im;
    logic signed [7:0]  out_d [8];
    logic signed [7:0]  out_q [8];

    // Twiddle products and final butterflies; -j*O2 is just a swap/negate.
    always_comb begin
        w1_re = tw_scale(ext10(c1_re_q[1]) + ext10(c1_im_q[1]));
        w1_im = tw_scale(ext10(c1_im_q[1]) - ext10(c1_re_q[1]));
        w3_re = tw_scale(ext10(c3_im_q[1]) - ext10(c3_re_q[1]));
        w3_im = tw_scale(-ext10(c3_re_q[1]) - ext10(c3_im_q[1]));

        x0_v  = ext10(r0_q[0]) + ext10(r0_q[1]);
        x4_v  = ext10(r0_q[0]) - ext10(r0_q[1]);
        x1_re = ext10(c1_re_q[0]) + w1_re;
        x1_im = ext10(c1_im_q[0]) + w1_im;
        x2_re = ext10(r2_q[0]);
        x2_im = -ext10(r2_q[1]);
        x3_re = ext10(c3_re_q[0]) + w3_re;
        x3_im = ext10(c3_im_q[0]) + w3_im;

        out_d[0] = out_scale(x0_v);
        out_d[1] = out_scale(x4_v);
        out_d[2] = out_scale(x1_re);
        out_d[3] = out_scale(x1_im);
        out_d[4] = out_scale(x2_re);
        out_d[5] = out_scale(x2_im);
        out_d[6] = out_scale(x3_re);
        out_d[7] = out_scale(x3_im);
    end

    // Output register.
    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            out_q <= out_d;
        end
    end

    assign out1 = out_q[0];
    assign out2 = out_q[1];
    assign out3 = out_q[2];
    assign out4 = out_q[3];
    assign out5 = out_q[4];
    assign out6 = out_q[5];
    assign out7 = out_q[6];
    assign out8 = out_q[7];

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the 8-point real FFT datapath.
module tb_datapath;

    typedef logic signed [7:0] vec8_t [8];

    logic  clk_1;
    logic  rst_n;
    vec8_t i_v;
    vec8_t o_v;

    int checks = 0;
    int errors = 0;

    vec8_t zero_in, imp_in, ramp_in, min_in, alt_in;
    vec8_t zero_ex, imp_ex, ramp_ex, min_ex, alt_ex;

    datapath dut (
        .clk_1 (clk_1),
        .rst_n (rst_n),
        .in1   (i_v[0]),
        .in2   (i_v[1]),
        .in3   (i_v[2]),
        .in4   (i_v[3]),
        .in5   (i_v[4]),
        .in6   (i_v[5]),
        .in7   (i_v[6]),
        .in8   (i_v[7]),
        .out1  (o_v[0]),
        .out2  (o_v[1]),
        .out3  (o_v[2]),
        .out4  (o_v[3]),
        .out5  (o_v[4]),
        .out6  (o_v[5]),
        .out7  (o_v[6]),
        .out8  (o_v[7])
    );

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_out(input string tag, input vec8_t ex);
        $display("%s: out = %0d %0d %0d %0d %0d %0d %0d %0d", tag,
                 o_v[0], o_v[1], o_v[2], o_v[3], o_v[4], o_v[5], o_v[6], o_v[7]);
        for (int k = 0; k < 8; k++) begin
            checks++;
            assert (o_v[k] === ex[k]) else begin
                errors++;
                $error("FAIL %s out%0d: observed %0d expected %0d", tag, k + 1, o_v[k], ex[k]);
            end
        end
    endtask

    task automatic edge_sample();
        @(posedge clk_1);
        #1;
    endtask

    initial begin
        zero_in = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        imp_in  = '{8'sd64, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        ramp_in = '{8'sd0, 8'sd16, 8'sd32, 8'sd48, 8'sd64, 8'sd80, 8'sd96, 8'sd112};
        min_in  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        alt_in  = '{8'sd100, -8'sd100, 8'sd100, -8'sd100, 8'sd100, -8'sd100, 8'sd100, -8'sd100};

        zero_ex = zero_in;
        imp_ex  = '{8'sd8, 8'sd8, 8'sd8, 8'sd0, 8'sd8, 8'sd0, 8'sd8, 8'sd0};
        ramp_ex = '{8'sd56, -8'sd8, -8'sd8, 8'sd19, -8'sd8, 8'sd8, -8'sd8, 8'sd3};
        min_ex  = '{8'h80, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
        alt_ex  = '{8'sd0, 8'sd100, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};

        // Reset held low with non-zero inputs while the clock runs.
        rst_n = 1'b0;
        i_v   = ramp_in;
        edge_sample();
        edge_sample();
        check_out("reset_hold", zero_ex);

        // Release and apply impulse: zeros for two edges, result after third.
        @(negedge clk_1);
        rst_n = 1'b1;
        i_v   = imp_in;
        edge_sample();
        check_out("post_reset_e1", zero_ex);
        edge_sample();
        check_out("post_reset_e2", zero_ex);
        edge_sample();
        check_out("impulse", imp_ex);

        // Ramp exercises the twiddle multipliers.
        @(negedge clk_1);
        i_v = ramp_in;
        edge_sample();
        edge_sample();
        edge_sample();
        check_out("ramp", ramp_ex);

        // All inputs at the negative extreme.
        @(negedge clk_1);
        i_v = min_in;
        edge_sample();
        edge_sample();
        edge_sample();
        check_out("const_min", min_ex);

        // Alternating signs: energy only in X4.
        @(negedge clk_1);
        i_v = alt_in;
        edge_sample();
        edge_sample();
        edge_sample();
        check_out("alternating", alt_ex);

        // Back-to-back frames on consecutive edges.
        @(negedge clk_1);
        i_v = imp_in;
        edge_sample();
        @(negedge clk_1);
        i_v = ramp_in;
        edge_sample();
        @(negedge clk_1);
        i_v = alt_in;
        edge_sample();
        check_out("b2b_impulse", imp_ex);
        @(negedge clk_1);
        i_v = zero_in;
        edge_sample();
        check_out("b2b_ramp", ramp_ex);
        edge_sample();
        check_out("b2b_alternating", alt_ex);

        // Mid-stream reset: outputs hold a non-zero frame, then reset mid-cycle.
        @(negedge clk_1);
        i_v = alt_in;
        edge_sample();
        edge_sample();
        edge_sample();
        check_out("pre_reset_alt", alt_ex);
        @(negedge clk_1);
        i_v = ramp_in;
        @(posedge clk_1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", zero_ex);

        // Release; in-flight frames must be gone, impulse appears after 3rd edge.
        @(negedge clk_1);
        rst_n = 1'b1;
        i_v   = imp_in;
        edge_sample();
        check_out("rerun_e1", zero_ex);
        edge_sample();
        check_out("rerun_e2", zero_ex);
        edge_sample();
        check_out("rerun_impulse", imp_ex);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
